// File: rtl/uart_tx_core.sv
// Transmit-only UART core: byte FIFO feeding an 8N1 serializer with registered line outputs.
// sim_tx_valid/sim_tx_data mirror each frame start so a bench can observe bytes without decoding the line.
module uart_tx_core #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          wr_en,
   input  logic [7:0]                    wr_data,
   input  logic                          ovf_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          fifo_full,
   output logic                          fifo_empty,
   output logic                          overflow,
   output logic                          tx_busy,
   output logic                          uart_tx,
   output logic                          sim_tx_valid,
   output logic [7:0]                    sim_tx_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLK_DIV);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state, state_nxt;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;
   logic [7:0]      shift;
   logic            push, pop, bit_end;
   logic [7:0]      head;

   assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign push       = wr_en && !fifo_full;
   assign head       = mem[rd_ptr];
   assign bit_end    = (baud_cnt == BAUD_LAST);
   assign tx_busy    = (state != IDLE);

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE:  if (!fifo_empty) begin
                   state_nxt = START;
                   pop       = 1'b1;
                end
         START: if (bit_end) state_nxt = DATA;
         DATA:  if (bit_end && bit_cnt == 3'd7) state_nxt = STOP;
         STOP:  if (bit_end) begin
                   if (!fifo_empty) begin
                      state_nxt = START;
                      pop       = 1'b1;
                   end else begin
                      state_nxt = IDLE;
                   end
                end
         default: state_nxt = IDLE;
      endcase
   end

   // Line outputs are updated on the same edge as the state, so uart_tx always matches the current bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt     <= '0;
         bit_cnt      <= '0;
         shift        <= '0;
         uart_tx      <= 1'b1;
         sim_tx_valid <= 1'b0;
         sim_tx_data  <= '0;
      end else begin
         sim_tx_valid <= pop;
         if (pop) begin
            shift       <= head;
            sim_tx_data <= head;
            uart_tx     <= 1'b0;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
         end else if (state != IDLE) begin
            if (bit_end) begin
               baud_cnt <= '0;
               case (state)
                  START: begin
                     uart_tx <= shift[0];
                     shift   <= shift >> 1;
                  end
                  DATA: begin
                     if (bit_cnt == 3'd7) begin
                        uart_tx <= 1'b1;
                     end else begin
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
                  default: uart_tx <= 1'b1;
               endcase
            end else begin
               baud_cnt <= baud_cnt + 1'b1;
            end
         end
      end
   end

   // NOTE: the storage array is not reset; the pointers and count alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
         // A dropped write outranks a simultaneous clear.
         if (wr_en && fifo_full) overflow <= 1'b1;
         else if (ovf_clr)       overflow <= 1'b0;
      end
   end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 16: clk cycles per serial bit; legal values are 2 or greater.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16: transmit FIFO entries; must be a power of two.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all logic runs on the rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL provide port wr_en, input, 1 bit: byte-write strobe from the MMIO THR register.
REQ-006 SHALL provide port wr_data, input, 8 bits: the byte to transmit.
REQ-007 SHALL provide port ovf_clr, input, 1 bit: clears the overflow flag.
REQ-008 SHALL provide port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: number of queued bytes.
REQ-009 SHALL provide port fifo_full, output, 1 bit: asserted when fifo_count == FIFO_DEPTH.
REQ-010 SHALL provide port fifo_empty, output, 1 bit: asserted when fifo_count == 0.
REQ-011 SHALL provide port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-012 SHALL provide port tx_busy, output, 1 bit: asserted while a frame is on the line.
REQ-013 SHALL provide port uart_tx, output, 1 bit: serial line, idle high.
REQ-014 SHALL provide port sim_tx_valid, output, 1 bit: one-cycle pulse at the start of each frame.
REQ-015 SHALL provide port sim_tx_data, output, 8 bits: the byte being framed; valid while sim_tx_valid is high.

Function
REQ-016 SHALL frame each byte as 8N1: start bit 0, data bits LSB first, stop bit 1; each bit lasts exactly CLK_DIV cycles.
REQ-017 SHALL implement FSM states IDLE, START, DATA, STOP:
- IDLE->START when the FIFO is non-empty.
- START->DATA after CLK_DIV cycles.
- DATA->STOP after 8 bits.
- STOP->START on the last stop-bit cycle if the FIFO is non-empty; otherwise STOP->IDLE.
REQ-018 SHALL pop the FIFO on each transition into START and load the popped byte into the shift register.
REQ-019 SHALL register uart_tx, sim_tx_valid and sim_tx_data: for a wr_en in cycle N with the FIFO empty and the FSM in IDLE, sim_tx_valid is high and uart_tx is 0 in cycle N+2.
REQ-020 SHALL transmit queued bytes back-to-back with no idle gap: one byte per 10*CLK_DIV cycles.
REQ-021 SHALL restart the bit counter at 0 on every transition into START.
REQ-022 SHALL accept a write only if fifo_full is 0 in that cycle.
REQ-023 SHALL, when wr_en arrives while fifo_full is 1, drop the byte and set overflow, even if a pop occurs in the same cycle.
REQ-024 SHALL, on a simultaneous accepted write and pop, leave fifo_count unchanged and preserve byte order.
REQ-025 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH.
REQ-026 SHALL keep overflow set until ovf_clr; if ovf_clr and a dropped write coincide, set wins.
REQ-027 SHALL drive tx_busy = 1 in START, DATA and STOP, and 0 in IDLE.

Reset
REQ-028 SHALL, on rst, set: FSM=IDLE, uart_tx=1, sim_tx_valid=0, sim_tx_data=0, fifo_count=0, fifo_empty=1, fifo_full=0, overflow=0, tx_busy=0, pointers=0.
REQ-029 SHALL let rst take priority over wr_en and ovf_clr.
REQ-030 SHALL, on rst asserted mid-frame, abort the frame: uart_tx=1 in the next cycle, queued bytes discarded.
REQ-031 SHALL produce no sim_tx_valid pulse after rst until a new write.

Verification (CLK_DIV=4, FIFO_DEPTH=16)
REQ-032 SHALL test reset: hold rst 3 cycles -> uart_tx=1, sim_tx_valid=0, fifo_empty=1, fifo_count=0, overflow=0.
REQ-033 SHALL test a single byte: wr_data=0x41 in cycle 0 ->
- sim_tx_valid=1 with sim_tx_data=0x41 in cycle 2 only.
- uart_tx bits 0,1,0,0,0,0,0,1,0,1, 4 cycles each, over cycles 2..41.
- tx_busy=0 from cycle 42.
REQ-034 SHALL test overflow: write 0x00..0x13 in cycles 0..19 ->
- bytes 0x00..0x10 accepted; fifo_full=1 after cycle 16.
- overflow=1 after cycle 17.
- exactly 17 sim_tx_valid pulses, 40 cycles apart, with data 0x00..0x10 in order.
REQ-035 SHALL test reset mid-frame: rst in cycle 20 of a frame with 5 bytes queued -> cycle 21: uart_tx=1, fifo_count=0; no sim_tx_valid within the next 100 cycles.
REQ-036 SHALL test overflow clear: with overflow=1, pulse ovf_clr -> overflow=0 next cycle; then ovf_clr together with a dropped write -> overflow=1.
REQ-037 SHALL test back-to-back frames: write 0x55 then 0xAA in consecutive cycles -> the 0xAA start bit begins exactly 40 cycles after the 0x55 start bit, with no idle-high gap.
